// File: rtl/fifo_push_arbiter_pkg.sv
// Shared definitions for the two-requester FIFO push arbiter.
// Holds the state encoding and the default byte/burst sizing.
package fifo_push_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing the FIFO push port between two burst producers.
// Grant is registered (one bubble from IDLE); data path is combinational and stalls on fifo_full.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              fifo_full,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_push_data,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  arb_state_t state, next_state;
  logic       prio, next_prio;
  logic [3:0] beat_cnt, next_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      prio     <= next_prio;
      beat_cnt <= next_cnt;
    end
  end

  // Owner/other views of the requesters, selected by which grant state is active.
  logic              own_valid, own_last, oth_valid, owner;
  logic [DATA_W-1:0] own_data;
  logic [3:0]        cnt_inc;
  logic              beat, burst_done, abandon;

  always_comb begin
    owner     = (state == GNT1);
    own_valid = owner ? req1_valid : req0_valid;
    own_data  = owner ? req1_data  : req0_data;
    own_last  = owner ? req1_last  : req0_last;
    oth_valid = owner ? req0_valid : req1_valid;
    cnt_inc   = beat_cnt + 4'd1;

    next_state     = state;
    next_prio      = prio;
    next_cnt       = beat_cnt;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_data = '0;
    beat           = 1'b0;
    burst_done     = 1'b0;
    abandon        = 1'b0;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          next_state = prio ? GNT1 : GNT0;
        end else if (req0_valid) begin
          next_state = GNT0;
        end else if (req1_valid) begin
          next_state = GNT1;
        end
      end
      GNT0, GNT1: begin
        req0_ready     = ~owner & ~fifo_full;
        req1_ready     = owner & ~fifo_full;
        fifo_push      = own_valid & ~fifo_full;
        fifo_push_data = own_data;
        beat           = own_valid & ~fifo_full;
        burst_done     = beat & (own_last | (cnt_inc == MAX_B));
        abandon        = ~own_valid;
        if (beat) begin
          next_cnt = cnt_inc;
        end
        if (burst_done || abandon) begin
          next_prio = ~owner;
          next_cnt  = 4'd0;
          // Other side waiting gets the port; otherwise a full burst may reopen for the same owner.
          if (oth_valid) begin
            next_state = owner ? GNT0 : GNT1;
          end else if (burst_done) begin
            next_state = state;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign grant = {state == GNT1, state == GNT0};
  assign busy  = (state != IDLE);

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Two-requester round-robin arbiter that shares the single push port of the 8-bit, 4-entry `fifo` between two byte producers. Each requester uses a valid/ready/last burst handshake; the arbiter grants one requester at a time, forwards its bytes to `push`/`push_data` only while the FIFO is not full, and hands over the port at burst end or after `MAX_BURST` beats. It sits directly in front of the FIFO write side; the FIFO pop side is untouched.

## Interface

- `DATA_W`, 8, byte width; must match the FIFO `push_data` width.
- `MAX_BURST`, 4, maximum beats per grant before a forced handover (range 1..15).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  DATA_W  requester 0 byte.
- `req0_last`  in  1  byte is the last of requester 0's burst.
- `req0_ready`  out  1  requester 0 byte accepted this cycle when high with valid.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0.
- `fifo_full`  in  1  FIFO `full` output.
- `fifo_push`  out  1  to FIFO `push`.
- `fifo_push_data`  out  DATA_W  to FIFO `push_data`.
- `grant`  out  2  one-hot current owner (bit0 = req0, bit1 = req1), 00 when idle.
- `busy`  out  1  high in any grant state.

## Operation

- States: IDLE, GNT0, GNT1. Registers: state, `prio` (1 bit, 0 = req0 wins ties), `beat_cnt` (4 bits).
- IDLE: if exactly one valid, go to its GNT state; if both, go to GNT`prio`; if none, stay. No data moves in IDLE.
- GNTx: `reqx_ready = ~fifo_full`; other requester's ready = 0. `fifo_push = reqx_valid & ~fifo_full`; `fifo_push_data = reqx_data`. Beat = `reqx_valid & reqx_ready`; each beat increments `beat_cnt`.
- Release condition in GNTx: beat with `reqx_last`, or beat making `beat_cnt == MAX_BURST`, or `reqx_valid == 0` (requester abandoned; no beat).
- On release: `prio` ← other requester; `beat_cnt` ← 0; next state = GNT(other) if other's valid is high this cycle, else GNTx if `reqx_valid` stays high and release was by last/MAX_BURST (new burst, same owner), else IDLE.
- While `fifo_full` is high in GNTx: no beat, no counter change, no release unless valid is low; grant is held indefinitely.
- Outside grant: both readys 0, `fifo_push` 0, `fifo_push_data` 0.
- Requester contract: once valid is high, data/last are held until the beat; the arbiter does not check this.

## Timing

- Reset (async assert, sync release on next edge): state IDLE, `prio` 0, `beat_cnt` 0; `grant` 00, `busy` 0, both readys 0, `fifo_push` 0, `fifo_push_data` 0.
- Arbitration latency from IDLE: valid at edge N → grant at N+1 → first beat accepted in the cycle after N+1 (one idle bubble).
- Back-to-back handover GNTx→GNTy: no bubble; y's first beat may occur in the first cycle of GNTy.
- Readys, `fifo_push`, `fifo_push_data` are combinational from state, valids, data and `fifo_full`; `grant`, `busy` are decoded from registered state only.
- `fifo_full` is the FIFO's registered flag, so a push in the cycle the FIFO reaches 4 entries is already blocked in that cycle; push is never driven while `fifo_full` is high.
- Reset mid-burst discards the burst; the requester must retransmit it.

## Structure

- Shared package: state encoding constants (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2), default `DATA_W`.
- Single module, no sub-module; the top-level integration instantiates `fifo_push_arbiter` next to `fifo`.
- Separate state/counter register block (async reset) and combinational next-state/output block.

## Test plan

- Single req0 burst A1,A2,A3 (last on A3), FIFO empty → grant 01 one cycle after valid, FIFO holds A1,A2,A3, grant 00 afterward, `prio` = 1.
- Both valid at reset release, req0 bursts 2 beats, req1 bursts 2 beats → req0 served first, handover to req1 with no bubble, FIFO order req0,req0,req1,req1.
- req0 streams 6 bytes with no last, MAX_BURST=4, req1 valid → 4 req0 beats, then req1's burst, then req0 resumes the remaining 2.
- Fifo filled to 4 (no pop), req0 holding 0x55 → `fifo_push` and `req0_ready` stay 0 and grant stays 01; pop one entry → 0x55 pushed the cycle after full drops.
- req1 granted, drops valid without last → return to IDLE (or to GNT0 if req0 valid) next cycle, no push.
- Assert `rst` after 2 beats of a 4-beat burst → all outputs return to reset values immediately; after release, arbitration restarts from IDLE with req0 priority.
